// File: rtl/alu_unit.sv
// alu_unit: 8-bit combinational ALU with optional registered status flags.
//
// Ports:
//   Clk       in   rising-edge clock for the flag registers only
//   Reset     in   asynchronous active-high reset of the flags
//   InputA    in   [7:0] operand A (unsigned)
//   InputB    in   [7:0] operand B (unsigned), also the shift amount
//   OP        in   [2:0] operation select
//   LSFT      in   shift direction for OP=111 (1 = left, 0 = right)
//   Branches  in   [1:0] compare sub-op for OP=110
//   Out       out  [7:0] combinational result, independent of Clk/Reset
//   Equal     out  registered InputA==InputB
//   Even      out  registered Out[0]==0
//   Zero      out  registered Out==0
//
// Build option: define ALU_FLAGS_EN to implement the flag registers.
// When it is undefined, the flag ports remain but are tied low.
module alu_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] InputA,
  input  logic [7:0] InputB,
  input  logic [2:0] OP,
  input  logic       LSFT,
  input  logic [1:0] Branches,
  output logic [7:0] Out,
  output logic       Equal,
  output logic       Even,
  output logic       Zero
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_ADDI  = 3'b001,
    OP_AND   = 3'b010,
    OP_XOR   = 3'b011,
    OP_RSV4  = 3'b100,
    OP_RSV5  = 3'b101,
    OP_CMP   = 3'b110,
    OP_SHIFT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    BR_LT     = 2'b00,
    BR_NE     = 2'b01,
    BR_EQ     = 2'b10,
    BR_ALWAYS = 2'b11
  } br_e;

  // Reserved and unknown opcodes fall through to the zero default.
  always_comb begin
    Out = '0;
    case (OP)
      OP_ADD, OP_ADDI: Out = InputA + InputB;
      OP_AND:          Out = InputA & InputB;
      OP_XOR:          Out = InputA ^ InputB;
      OP_CMP: begin
        case (Branches)
          BR_LT:     Out = {7'b0, (InputA < InputB)};
          BR_NE:     Out = {7'b0, (InputA != InputB)};
          BR_EQ:     Out = {7'b0, (InputA == InputB)};
          BR_ALWAYS: Out = 8'd1;
          default:   Out = '0;
        endcase
      end
      OP_SHIFT: begin
        // Full 8-bit shift amount: anything >= 8 clears the result.
        if (InputB >= 8'd8)
          Out = '0;
        else if (LSFT)
          Out = InputA << InputB[2:0];
        else
          Out = InputA >> InputB[2:0];
      end
      default: Out = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Equal <= 1'b0;
      Even  <= 1'b0;
      Zero  <= 1'b0;
    end else begin
      Equal <= (InputA == InputB);
      Even  <= ~Out[0];
      Zero  <= (Out == '0);
    end
  end
`else
  assign Equal = 1'b0;
  assign Even  = 1'b0;
  assign Zero  = 1'b0;

  // Clock and reset only feed the flag registers, absent in this build.
  logic unused_clk_rst;
  assign unused_clk_rst = ^{Clk, Reset};
`endif

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] InputA, InputB;
  logic [2:0] OP;
  logic       LSFT;
  logic [1:0] Branches;
  logic [7:0] Out;
  logic       Equal, Even, Zero;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  alu_unit dut (
    .Clk(Clk), .Reset(Reset), .InputA(InputA), .InputB(InputB), .OP(OP),
    .LSFT(LSFT), .Branches(Branches), .Out(Out), .Equal(Equal), .Even(Even),
    .Zero(Zero)
  );

  always #5 Clk = ~Clk;

  // Reference result computed with plain integer arithmetic.
  function automatic int model_out(int a, int b, int op, int lsft, int br);
    case (op)
      0, 1: return (a + b) % 256;
      2:    return a & b;
      3:    return a ^ b;
      6: begin
        case (br)
          0: return (a < b) ? 1 : 0;
          1: return (a != b) ? 1 : 0;
          2: return (a == b) ? 1 : 0;
          default: return 1;
        endcase
      end
      7: begin
        if (b >= 8) return 0;
        if (lsft != 0) return (a * (2 ** b)) % 256;
        return a / (2 ** b);
      end
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int op, input int lsft,
                       input int br);
    InputA = 8'(a); InputB = 8'(b); OP = 3'(op); LSFT = 1'(lsft); Branches = 2'(br);
    #1;
  endtask

  task automatic directed(input string name, input int a, input int b, input int op,
                          input int lsft, input int br, input int exp);
    drive(a, b, op, lsft, br);
    check(name, int'(Out), exp);
    check({name, "_model"}, model_out(a, b, op, lsft, br), exp);
  endtask

  // Per-cycle checker: Out against the model now, flags against the inputs
  // that were stable across the preceding rising edge.
  int  p_a, p_b, p_op, p_lsft, p_br;
  bit  p_rst;
  bit  have_prev = 1'b0;

  always @(negedge Clk) begin
    if (chk_en) begin
      int m, pm;
      bit eq, ev, zr;
      m = model_out(int'(InputA), int'(InputB), int'(OP), int'(LSFT), int'(Branches));
      check("rand_out", int'(Out), m);
      if (have_prev) begin
        eq = 1'b0; ev = 1'b0; zr = 1'b0;
        if (FLAGS && !Reset && !p_rst) begin
          pm = model_out(p_a, p_b, p_op, p_lsft, p_br);
          eq = (p_a == p_b);
          ev = (pm % 2 == 0);
          zr = (pm == 0);
        end
        check("rand_equal", int'(Equal), int'(eq));
        check("rand_even",  int'(Even),  int'(ev));
        check("rand_zero",  int'(Zero),  int'(zr));
      end
      p_a = int'(InputA); p_b = int'(InputB); p_op = int'(OP);
      p_lsft = int'(LSFT); p_br = int'(Branches); p_rst = Reset;
      have_prev = 1'b1;
    end
  end

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    check("reset_equal", int'(Equal), 0);
    check("reset_even",  int'(Even),  0);
    check("reset_zero",  int'(Zero),  0);

    directed("shl_27_2",   27,  2, 7, 1, 0, 8'h6C);
    directed("shr_4_2",     4,  2, 7, 0, 0, 8'h01);
    directed("shr_4_9",     4,  9, 7, 0, 0, 8'h00);
    directed("shl_ff_8",  255,  8, 7, 1, 0, 8'h00);
    directed("shr_80_7", 128,  7, 7, 0, 0, 8'h01);
    directed("add_wrap",  200, 100, 0, 0, 0, 8'h2C);
    directed("addi_wrap", 200, 100, 1, 0, 0, 8'h2C);
    directed("cmp_lt",      3,  5, 6, 1, 0, 1);
    directed("cmp_ne",      3,  5, 6, 0, 1, 1);
    directed("cmp_eq",      3,  5, 6, 0, 2, 0);
    directed("cmp_always",  3,  5, 6, 0, 3, 1);
    directed("cmp_lt_eqv",  5,  5, 6, 0, 0, 0);
    directed("and",      8'hAA, 8'h0F, 2, 0, 0, 8'h0A);
    directed("xor",      8'hAA, 8'h0F, 3, 0, 0, 8'hA5);
    directed("rsv4",     8'hAA, 8'h0F, 4, 1, 3, 8'h00);
    directed("rsv5",     8'hAA, 8'h0F, 5, 0, 0, 8'h00);
    directed("add_lsft_ignored", 1, 2, 0, 1, 3, 3);

    // Flag load then asynchronous reset mid-cycle.
    @(negedge Clk);
    Reset = 1'b0;
    drive(8'h10, 8'h10, 3, 0, 0);
    @(posedge Clk); #1;
    check("flag_equal", int'(Equal), int'(FLAGS));
    check("flag_even",  int'(Even),  int'(FLAGS));
    check("flag_zero",  int'(Zero),  int'(FLAGS));
    #2 Reset = 1'b1;
    #1;
    check("arst_equal", int'(Equal), 0);
    check("arst_even",  int'(Even),  0);
    check("arst_zero",  int'(Zero),  0);
    check("arst_out",   int'(Out),   0);

    // Randomized phase with occasional reset pulses.
    @(posedge Clk); #2;
    chk_en = 1'b1;
    repeat (500) begin
      @(posedge Clk); #2;
      Reset    = ($urandom % 20 == 0);
      InputA   = 8'($urandom);
      InputB   = ($urandom % 2 != 0) ? 8'($urandom % 12) : 8'($urandom);
      if ($urandom % 4 == 0) InputB = InputA;
      OP       = 3'($urandom);
      LSFT     = 1'($urandom);
      Branches = 2'($urandom);
    end
    @(posedge Clk);
    @(negedge Clk);
    #1 chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter: none; datapath width is fixed at 8 bits.
REQ-002 Clk  input  1  rising-edge clock for the flag registers; the result path does not use it.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 InputA  input  8  operand A, unsigned.
REQ-005 InputB  input  8  operand B, unsigned; also the shift amount.
REQ-006 OP  input  3  operation select.
REQ-007 LSFT  input  1  shift direction when OP=111: 1 = left, 0 = right.
REQ-008 Branches  input  2  compare sub-op when OP=110.
REQ-009 Out  output  8  combinational result.
REQ-010 Equal  output  1  registered flag, InputA==InputB.
REQ-011 Even  output  1  registered flag, Out[0]==0.
REQ-012 Zero  output  1  registered flag, Out==0.

Function
REQ-013 Out SHALL be purely combinational from InputA, InputB, OP, LSFT and Branches, with zero-cycle latency.
REQ-014 OP=000 (ADD) and OP=001 (ADDI) SHALL both give Out = (InputA+InputB) mod 256; carry is discarded.
REQ-015 OP=010 SHALL give Out = InputA AND InputB, bitwise.
REQ-016 OP=011 SHALL give Out = InputA XOR InputB, bitwise.
REQ-017 OP=100 and OP=101 are reserved and SHALL give Out = 8'h00.
REQ-018 OP=110 with Branches=00 SHALL give Out = 1 when InputA<InputB (unsigned) and 0 otherwise; Out[7:1] = 0.
REQ-019 OP=110 with Branches=01 SHALL give Out = 1 when InputA!=InputB and 0 otherwise.
REQ-020 OP=110 with Branches=10 SHALL give Out = 1 when InputA==InputB and 0 otherwise.
REQ-021 OP=110 with Branches=11 SHALL give Out = 1 unconditionally.
REQ-022 OP=111 with LSFT=1 SHALL give Out = InputA << InputB, logical shift with zero fill.
REQ-023 OP=111 with LSFT=0 SHALL give Out = InputA >> InputB, logical shift with zero fill.
REQ-024 For any shift with InputB >= 8, the full 8-bit value of InputB is used and Out SHALL be 8'h00.
REQ-025 LSFT SHALL be ignored unless OP=111; Branches SHALL be ignored unless OP=110.
REQ-026 On each rising edge of Clk with Reset low, Equal, Even and Zero SHALL capture their values as computed from the current inputs and Out.
REQ-027 The flags SHALL update on every clock edge; there is no enable and no hold.
REQ-028 Any X or Z on OP SHALL be treated as a reserved code and give Out = 8'h00.

Reset
REQ-029 While Reset is high, Equal, Even and Zero SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 Out SHALL NOT be affected by Reset and SHALL remain a function of the inputs only.
REQ-031 On the first rising edge of Clk after Reset deasserts, the flags SHALL load normally.

Configuration
REQ-032 Macro ALU_FLAGS_EN defined: the Equal, Even and Zero registers SHALL be implemented as specified in REQ-026 to REQ-029.
REQ-033 Macro ALU_FLAGS_EN undefined: the Equal, Even and Zero ports SHALL remain present but be tied to constant 0, and no flag registers SHALL exist.
REQ-034 Out behaviour SHALL be identical whether or not ALU_FLAGS_EN is defined.

Verification
REQ-035 A=27, B=2, OP=111, LSFT=1 -> Out = 8'h6C (108).
REQ-036 A=4, B=2, OP=111, LSFT=0 -> Out = 8'h01; repeat with B=9 -> Out = 8'h00.
REQ-037 A=200, B=100, OP=000, then OP=001 -> Out = 8'h2C (44) in both cases.
REQ-038 A=3, B=5, OP=110 -> Branches=00 gives 1, Branches=01 gives 1, Branches=10 gives 0, Branches=11 gives 1; A=0xAA, B=0x0F -> OP=010 gives 8'h0A, OP=011 gives 8'hA5, OP=100 gives 8'h00.
REQ-039 With ALU_FLAGS_EN defined, A=B=8'h10, OP=011 (Out = 0), one Clk edge -> Equal=1, Even=1, Zero=1; then assert Reset mid-cycle -> all flags go to 0 immediately while Out stays 8'h00.
